forward_propagation_param: RTL and testbench

- Parametrised successor of the fixed 2-2-1 forward-propagation engine.
- Computes a 2-input, N_HID-hidden, 1-output MLP forward pass in signed fixed point. Uses one shared multiplier, time-multiplexed over one product per clock.
- Hidden and output activations are selectable at run time. Accumulation saturates and raises a sticky overflow flag.
- Hidden activations and the output pre-activation are exported to the backprop stage.

---
 rtl/forward_propagation_param_if.sv | 30 +++
 rtl/forward_propagation_param.sv | 192 +++++++++++++++++++
 tb/tb_forward_propagation_param.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/forward_propagation_param_if.sv
// rtl/forward_propagation_param_if.sv - request/operand/result bundle for the MLP forward engine
interface forward_propagation_param_if #(
  parameter int DW    = 16,
  parameter int N_HID = 2
);
  logic                    start;
  logic                    hid_act_sel;
  logic                    out_act_sel;
  logic [2*DW-1:0]         x_flat;
  logic [2*N_HID*DW-1:0]   w_hid_flat;
  logic [N_HID*DW-1:0]     b_hid_flat;
  logic [N_HID*DW-1:0]     w_out_flat;
  logic [DW-1:0]           b_out;
  logic                    busy;
  logic                    valid;
  logic [DW-1:0]           y;
  logic [DW-1:0]           z_out;
  logic [N_HID*DW-1:0]     h_flat;
  logic                    ovf;

  modport master (
    output start, hid_act_sel, out_act_sel, x_flat, w_hid_flat, b_hid_flat, w_out_flat, b_out,
    input  busy, valid, y, z_out, h_flat, ovf
  );

  modport slave (
    input  start, hid_act_sel, out_act_sel, x_flat, w_hid_flat, b_hid_flat, w_out_flat, b_out,
    output busy, valid, y, z_out, h_flat, ovf
  );
endinterface

// File: rtl/forward_propagation_param.sv
// rtl/forward_propagation_param.sv - 2-input, N_HID-hidden, 1-output MLP forward pass
// One shared multiplier, one product per clock; saturating accumulation with sticky overflow.
module forward_propagation_param #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int N_HID = 2
) (
  input logic clk,
  input logic rst,
  forward_propagation_param_if.slave bus
);
  localparam int AW = 2*DW + 4;
  localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HMAC = 3'd1;
  localparam logic [2:0] S_HACT = 3'd2;
  localparam logic [2:0] S_OMAC = 3'd3;
  localparam logic [2:0] S_OACT = 3'd4;

  localparam logic signed [AW-1:0]   SAT_MAX = AW'((64'sd1 <<< (DW-1)) - 64'sd1);
  localparam logic signed [AW-1:0]   SAT_MIN = ~SAT_MAX;
  localparam logic signed [DW+1:0]   ONE_W   = (DW+2)'(1 <<< FRAC);
  localparam logic signed [DW+1:0]   HALF    = ONE_W >>> 1;
  localparam logic [JW-1:0]          J_LAST  = JW'(N_HID - 1);

  logic [2:0]              state;
  logic signed [DW-1:0]    x_r [2];
  logic signed [DW-1:0]    w_r [2*N_HID];
  logic signed [DW-1:0]    b_r [N_HID];
  logic signed [DW-1:0]    v_r [N_HID];
  logic signed [DW-1:0]    h_r [N_HID];
  logic signed [DW-1:0]    bo_r;
  logic                    hsel_r, osel_r;
  logic [JW-1:0]           j;
  logic                    i;
  logic signed [AW-1:0]    acc;
  logic                    ovf_pass;

  logic                    busy_r, valid_r, ovf_r;
  logic [DW-1:0]           y_r, z_r;
  logic [N_HID*DW-1:0]     h_flat_r;

  logic [JW-1:0]           j_nxt;
  logic signed [DW-1:0]    mul_a, mul_b;
  logic signed [2*DW-1:0]  prod, prod_sh;
  logic signed [AW-1:0]    acc_add;
  logic                    clamp;
  logic signed [DW-1:0]    z_sat, hid_act, out_act;

  function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] v);
    return {{(AW-DW){v[DW-1]}}, v};
  endfunction

  // 0.5 + z/4 limited to [0, one]; the shift floors toward -inf like the MAC path
  function automatic logic signed [DW-1:0] hsig(input logic signed [DW-1:0] z);
    logic signed [DW+1:0] t;
    t = ($signed({{2{z[DW-1]}}, z}) >>> 2) + HALF;
    if (t[DW+1])
      return '0;
    else if (t > ONE_W)
      return ONE_W[DW-1:0];
    else
      return t[DW-1:0];
  endfunction

  assign j_nxt = j + 1'b1;

  always_comb begin
    mul_a = w_r[{j, i}];
    mul_b = x_r[i];
    if (state == S_OMAC) begin
      mul_a = v_r[j];
      mul_b = h_r[j];
    end
  end

  assign prod    = mul_a * mul_b;
  assign prod_sh = prod >>> FRAC;
  assign acc_add = acc + {{(AW-2*DW){prod_sh[2*DW-1]}}, prod_sh};

  always_comb begin
    clamp = 1'b0;
    z_sat = acc[DW-1:0];
    if (acc > SAT_MAX) begin
      clamp = 1'b1;
      z_sat = SAT_MAX[DW-1:0];
    end else if (acc < SAT_MIN) begin
      clamp = 1'b1;
      z_sat = SAT_MIN[DW-1:0];
    end
  end

  assign hid_act = hsel_r ? hsig(z_sat) : (z_sat[DW-1] ? '0 : z_sat);
  assign out_act = osel_r ? z_sat : hsig(z_sat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      x_r[0]   <= '0;
      x_r[1]   <= '0;
      for (int k = 0; k < 2*N_HID; k++) w_r[k] <= '0;
      for (int k = 0; k < N_HID; k++) begin
        b_r[k] <= '0;
        v_r[k] <= '0;
        h_r[k] <= '0;
      end
      bo_r     <= '0;
      hsel_r   <= 1'b0;
      osel_r   <= 1'b0;
      j        <= '0;
      i        <= 1'b0;
      acc      <= '0;
      ovf_pass <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      y_r      <= '0;
      z_r      <= '0;
      h_flat_r <= '0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            x_r[0] <= bus.x_flat[0 +: DW];
            x_r[1] <= bus.x_flat[DW +: DW];
            for (int k = 0; k < 2*N_HID; k++) w_r[k] <= bus.w_hid_flat[k*DW +: DW];
            for (int k = 0; k < N_HID; k++) begin
              b_r[k] <= bus.b_hid_flat[k*DW +: DW];
              v_r[k] <= bus.w_out_flat[k*DW +: DW];
            end
            bo_r     <= bus.b_out;
            hsel_r   <= bus.hid_act_sel;
            osel_r   <= bus.out_act_sel;
            ovf_pass <= 1'b0;
            busy_r   <= 1'b1;
            acc      <= sext(bus.b_hid_flat[0 +: DW]);
            j        <= '0;
            i        <= 1'b0;
            state    <= S_HMAC;
          end
        end
        S_HMAC: begin
          acc <= acc_add;
          i   <= ~i;
          if (i) state <= S_HACT;
        end
        S_HACT: begin
          h_r[j] <= hid_act;
          if (clamp) ovf_pass <= 1'b1;
          if (j == J_LAST) begin
            acc   <= sext(bo_r);
            j     <= '0;
            state <= S_OMAC;
          end else begin
            acc   <= sext(b_r[j_nxt]);
            j     <= j_nxt;
            state <= S_HMAC;
          end
        end
        S_OMAC: begin
          acc <= acc_add;
          if (j == J_LAST) begin
            j     <= '0;
            state <= S_OACT;
          end else begin
            j <= j_nxt;
          end
        end
        S_OACT: begin
          z_r   <= z_sat;
          y_r   <= out_act;
          for (int k = 0; k < N_HID; k++) h_flat_r[k*DW +: DW] <= h_r[k];
          // results and flag are published together so they never disagree mid-pass
          ovf_r   <= ovf_pass | clamp;
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.valid  = valid_r;
  assign bus.y      = y_r;
  assign bus.z_out  = z_r;
  assign bus.h_flat = h_flat_r;
  assign bus.ovf    = ovf_r;
endmodule

// File: tb/tb_forward_propagation_param.sv
// tb/tb_forward_propagation_param.sv - directed bench for forward_propagation_param (N_HID=2 and N_HID=4)
module tb_forward_propagation_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  forward_propagation_param_if #(.DW(16), .N_HID(2)) bus ();
  forward_propagation_param_if #(.DW(16), .N_HID(4)) bus4 ();

  forward_propagation_param #(.DW(16), .FRAC(8), .N_HID(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  forward_propagation_param #(.DW(16), .FRAC(8), .N_HID(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int tests = 0;
  int fails = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_xor;
    bus.hid_act_sel = 1'b0;
    bus.out_act_sel = 1'b0;
    bus.x_flat      = {16'h0100, 16'h0100};
    bus.w_hid_flat  = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    bus.b_hid_flat  = {16'hFF00, 16'h0000};
    bus.w_out_flat  = {16'hFC00, 16'h0200};
    bus.b_out       = 16'hFF80;
  endtask

  task automatic run_pass(output int lat);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: busy=%b valid=%b ovf=%b expected 0 0 0", bus.busy, bus.valid, bus.ovf);
    end
    tests++;
    if (bus.y !== 16'h0 || bus.z_out !== 16'h0 || bus.h_flat !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: y=%h z=%h h=%h expected 0", bus.y, bus.z_out, bus.h_flat);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_xor;
    int lat;
    load_xor();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.x_flat     = 32'hDEAD_BEEF;
    bus.w_hid_flat = 64'h1234_5678_9ABC_DEF0;
    bus.b_out      = 16'h7777;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.valid) begin
        lat = k;
        break;
      end
    end
    tests++;
    if (lat !== 9) begin
      fails++;
      $display("FAIL xor_latency: got %0d expected 9", lat);
    end
    tests++;
    if (bus.h_flat !== {16'h0100, 16'h0200}) begin
      fails++;
      $display("FAIL xor_h: got %h expected %h", bus.h_flat, {16'h0100, 16'h0200});
    end
    tests++;
    if (bus.z_out !== 16'hFF80) begin
      fails++;
      $display("FAIL xor_z: got %h expected ff80", bus.z_out);
    end
    tests++;
    if (bus.y !== 16'h0060 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL xor_y: got y=%h ovf=%b expected 0060 0", bus.y, bus.ovf);
    end
    tick();
    tests++;
    if (bus.valid !== 1'b0 || bus.y !== 16'h0060) begin
      fails++;
      $display("FAIL xor_pulse: valid=%b y=%h expected 0 0060", bus.valid, bus.y);
    end
  endtask

  task automatic test_saturation;
    int lat;
    bus.hid_act_sel = 1'b0;
    bus.out_act_sel = 1'b1;
    bus.x_flat      = {2{16'h7FFF}};
    bus.w_hid_flat  = {4{16'h7FFF}};
    bus.b_hid_flat  = {2{16'h7FFF}};
    bus.w_out_flat  = {2{16'h7FFF}};
    bus.b_out       = 16'h0000;
    run_pass(lat);
    tests++;
    if (lat !== 9 || bus.h_flat !== {2{16'h7FFF}}) begin
      fails++;
      $display("FAIL sat_h: lat=%0d h=%h expected 9 7fff7fff", lat, bus.h_flat);
    end
    tests++;
    if (bus.z_out !== 16'h7FFF || bus.y !== 16'h7FFF) begin
      fails++;
      $display("FAIL sat_out: z=%h y=%h expected 7fff 7fff", bus.z_out, bus.y);
    end
    tests++;
    if (bus.ovf !== 1'b1) begin
      fails++;
      $display("FAIL sat_ovf: got %b expected 1", bus.ovf);
    end
    tick();
    load_xor();
    run_pass(lat);
    tests++;
    if (bus.ovf !== 1'b0 || bus.y !== 16'h0060) begin
      fails++;
      $display("FAIL sat_clear: ovf=%b y=%h expected 0 0060", bus.ovf, bus.y);
    end
    tick();
  endtask

  task automatic test_sigmoid_clamp;
    logic [15:0] bo   [3] = '{16'd1000, 16'hFC18, 16'd0};
    logic [15:0] yexp [3] = '{16'd256, 16'd0, 16'd128};
    int lat;
    load_xor();
    bus.w_out_flat = '0;
    for (int t = 0; t < 3; t++) begin
      bus.b_out = bo[t];
      run_pass(lat);
      tests++;
      if (bus.y !== yexp[t] || bus.z_out !== bo[t]) begin
        fails++;
        $display("FAIL sig_clamp[%0d]: y=%h z=%h expected %h %h", t, bus.y, bus.z_out, yexp[t], bo[t]);
      end
      tick();
    end
  endtask

  task automatic test_handshake;
    int nvalid = 0;
    int first = -1;
    load_xor();
    bus.start = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      bus.start = (k >= 2 && k <= 5);
      tick();
      if (bus.valid) begin
        nvalid++;
        if (first < 0) first = k;
      end
    end
    bus.start = 1'b0;
    tests++;
    if (nvalid !== 1 || first !== 9) begin
      fails++;
      $display("FAIL ignore_start: valids=%0d first=%0d expected 1 9", nvalid, first);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    load_xor();
    run_pass(lat);
    bus.b_out = 16'h0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b expected 1", bus.busy);
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.valid) begin
        lat = k;
        break;
      end
    end
    tests++;
    if (lat !== 9 || bus.z_out !== 16'h0000 || bus.y !== 16'h0080) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d z=%h y=%h expected 9 0000 0080", lat, bus.z_out, bus.y);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int nvalid = 0;
    load_xor();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    tests++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.y !== 16'h0000) begin
      fails++;
      $display("FAIL mid_reset: busy=%b valid=%b y=%h expected 0 0 0000", bus.busy, bus.valid, bus.y);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.valid) nvalid++;
    end
    tests++;
    if (nvalid !== 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_quiet: valids=%0d busy=%b expected 0 0", nvalid, bus.busy);
    end
  endtask

  task automatic test_nhid4;
    int lat = -1;
    bus4.hid_act_sel = 1'b0;
    bus4.out_act_sel = 1'b1;
    bus4.x_flat      = {2{16'h0100}};
    bus4.w_hid_flat  = {8{16'h0100}};
    bus4.b_hid_flat  = '0;
    bus4.w_out_flat  = {4{16'h0100}};
    bus4.b_out       = 16'h0000;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus4.valid) begin
        lat = k;
        break;
      end
    end
    tests++;
    if (lat !== 17) begin
      fails++;
      $display("FAIL n4_latency: got %0d expected 17", lat);
    end
    tests++;
    if (bus4.h_flat !== {4{16'h0200}}) begin
      fails++;
      $display("FAIL n4_h: got %h expected %h", bus4.h_flat, {4{16'h0200}});
    end
    tests++;
    if (bus4.z_out !== 16'h0800 || bus4.y !== 16'h0800 || bus4.ovf !== 1'b0) begin
      fails++;
      $display("FAIL n4_out: z=%h y=%h ovf=%b expected 0800 0800 0", bus4.z_out, bus4.y, bus4.ovf);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.hid_act_sel  = 1'b0;
    bus.out_act_sel  = 1'b0;
    bus.x_flat       = '0;
    bus.w_hid_flat   = '0;
    bus.b_hid_flat   = '0;
    bus.w_out_flat   = '0;
    bus.b_out        = '0;
    bus4.start       = 1'b0;
    bus4.hid_act_sel = 1'b0;
    bus4.out_act_sel = 1'b0;
    bus4.x_flat      = '0;
    bus4.w_hid_flat  = '0;
    bus4.b_hid_flat  = '0;
    bus4.w_out_flat  = '0;
    bus4.b_out       = '0;
    test_reset();
    test_xor();
    test_saturation();
    test_sigmoid_clamp();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_nhid4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
